// File: rtl/clean_pulse_gen.sv
// Clean pulse generator: stretches a one-cycle request into a pulse of at least
// HOLD_CYCLES high followed by GAP_CYCLES low. Define PULSE_QUEUE_EN for a one-deep pending slot.
module clean_pulse_gen #(
   parameter int HOLD_CYCLES = 3,
   parameter int GAP_CYCLES  = 3,
   parameter int CW          = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic [CW-1:0] len,
   output logic          out,
   output logic          busy,
   output logic          done
);
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      HIGH = 3'b010,
      GAP  = 3'b100
   } state_t;

   localparam logic [CW-1:0] HOLD_L = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] GAP_M1 = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] req_cnt;

   // Counter load value for a fresh request: effective length minus one.
   assign req_cnt = ((len < HOLD_L) ? HOLD_L : len) - ONE;

`ifdef PULSE_QUEUE_EN
   logic          pend_valid_q, pend_valid_d;
   logic [CW-1:0] pend_cnt_q, pend_cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef PULSE_QUEUE_EN
      pend_valid_d = pend_valid_q;
      pend_cnt_d   = pend_cnt_q;
      if (state_q != IDLE && req && !pend_valid_q) begin
         pend_valid_d = 1'b1;
         pend_cnt_d   = req_cnt;
      end
`endif
      case (state_q)
         IDLE: begin
            out_d  = 1'b0;
            busy_d = 1'b0;
            if (req) begin
               state_d = HIGH;
               cnt_d   = req_cnt;
               out_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else begin
               state_d = GAP;
               cnt_d   = GAP_M1;
               out_d   = 1'b0;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
               busy_d  = 1'b0;
               out_d   = 1'b0;
`ifdef PULSE_QUEUE_EN
               // A request landing on the final gap cycle chains just like a stored one.
               if (pend_valid_q || req) begin
                  state_d = HIGH;
                  cnt_d   = pend_valid_q ? pend_cnt_q : req_cnt;
                  out_d   = 1'b1;
                  busy_d  = 1'b1;
               end
               pend_valid_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PULSE_QUEUE_EN
         pend_valid_q <= 1'b0;
         pend_cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef PULSE_QUEUE_EN
         pend_valid_q <= pend_valid_d;
         pend_cnt_q   <= pend_cnt_d;
`endif
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_clean_pulse_gen.sv
// Directed bench for clean_pulse_gen (default build): expected {out,busy,done}
// per cycle are queued when a request is driven and popped one per cycle.
module tb_clean_pulse_gen;
   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [3:0] len;
   logic       out, busy, done;

   int errors = 0;
   int checks = 0;
   logic [2:0] sb[$];

   clean_pulse_gen #(.HOLD_CYCLES(3), .GAP_CYCLES(3), .CW(4)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .len (len),
      .out (out),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input logic [2:0] v, input int n);
      for (int i = 0; i < n; i++) sb.push_back(v);
   endtask

   // Pulse of L high cycles, 3 gap cycles, one done strobe.
   task automatic push_pulse(input int L);
      push_n(3'b110, L);
      push_n(3'b010, 3);
      push_n(3'b001, 1);
   endtask

   task automatic check(input string tag);
      logic [2:0] exp;
      logic [2:0] obs;
      exp = sb.pop_front();
      obs = {out, busy, done};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0t obs(out,busy,done)=%b exp=%b", tag, $time, obs, exp);
      end
      $display("check %s t=%0t obs=%b exp=%b", tag, $time, obs, exp);
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         step();
         check(tag);
         guard++;
      end
   endtask

   task automatic one_pulse(input logic [3:0] l, input int L, input string tag);
      req = 1'b1;
      len = l;
      push_pulse(L);
      push_n(3'b000, 1);
      step();
      req = 1'b0;
      len = 4'($urandom);
      check(tag);
      drain(tag);
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      len = '0;
      #1;
      push_n(3'b000, 1);
      check("reset_async");
      step();
      push_n(3'b000, 1);
      check("reset_clocked");
      rst = 1'b0;
      push_n(3'b000, 1);
      drain("idle");

      one_pulse(4'd5,  5,  "len5");
      one_pulse(4'd1,  3,  "len1");
      one_pulse(4'd0,  3,  "len0");
      one_pulse(4'd15, 15, "len15");

      // req held every cycle: pulses start at cycles 1, 8, 15.
      req = 1'b1;
      len = 4'd3;
      push_pulse(3);
      push_pulse(3);
      push_pulse(3);
      push_n(3'b000, 1);
      for (int c = 1; c <= 22; c++) begin
         step();
         if (c >= 15) req = 1'b0;
         check("held_req");
      end

      // Async reset in the middle of the high phase (cycle 3).
      req = 1'b1;
      len = 4'd5;
      push_n(3'b110, 2);
      step();
      req = 1'b0;
      check("pre_rst");
      step();
      check("pre_rst");
      step();
      #2;
      rst = 1'b1;
      #1;
      push_n(3'b000, 1);
      check("rst_mid_high");
      step();
      rst = 1'b0;
      push_n(3'b000, 1);
      check("rst_hold");
      one_pulse(4'd4, 4, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
